// File: rtl/qspi_sram_responder.sv
// SQI serial-SRAM responder: sequential read (0x03) / write (0x02) against an internal byte array.
// cs_n, sck and sio are oversampled on clk; sck is never used as a clock.
`timescale 1ns/1ps
module qspi_sram_responder #(
   parameter int ADDR_WIDTH  = 10,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cs_n,
   input  logic                  sck,
   input  logic [3:0]            sio_i,
   output logic [3:0]            sio_o,
   output logic                  sio_oe,
   input  logic                  load_we,
   input  logic [ADDR_WIDTH-1:0] load_addr,
   input  logic [7:0]            load_data,
   output logic                  busy,
   output logic                  cmd_error
);

   typedef enum logic [2:0] {
      IDLE, CMD, ADDR, DUMMY, READ, WRITE, IGNORE
   } state_t;

   logic [SYNC_STAGES-1:0]      cs_sync;
   logic [SYNC_STAGES-1:0]      sck_sync;
   logic [SYNC_STAGES-1:0][3:0] sio_sync;
   logic                        sck_prev;

   logic       cs_s;
   logic       sck_s;
   logic [3:0] sio_s;
   logic       rise;
   logic       fall;

   state_t                state;
   logic [2:0]            nib_cnt;
   logic                  is_write;
   logic                  half;
   logic [23:0]           shift;
   logic [23:0]           shift_next;
   logic [ADDR_WIDTH-1:0] addr;
   logic [ADDR_WIDTH-1:0] addr_inc;
   logic [7:0]            data_sh;
   logic [3:0]            wr_hi;
   logic                  mem_we;

   logic [7:0] mem [2**ADDR_WIDTH];

   // cs_n resets to deselected so a reset never looks like a transaction start
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cs_sync  <= '1;
         sck_sync <= '0;
         sio_sync <= '0;
         sck_prev <= 1'b0;
      end else begin
         cs_sync  <= {cs_sync[SYNC_STAGES-2:0], cs_n};
         sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
         sio_sync <= {sio_sync[SYNC_STAGES-2:0], sio_i};
         sck_prev <= sck_sync[SYNC_STAGES-1];
      end
   end

   assign cs_s       = cs_sync[SYNC_STAGES-1];
   assign sck_s      = sck_sync[SYNC_STAGES-1];
   assign sio_s      = sio_sync[SYNC_STAGES-1];
   assign rise       = sck_s & ~sck_prev & ~cs_s;
   assign fall       = ~sck_s & sck_prev & ~cs_s;
   assign shift_next = {shift[19:0], sio_s};
   assign addr_inc   = addr + 1'b1;
   assign mem_we     = (state == WRITE) && rise && half;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         nib_cnt   <= '0;
         is_write  <= 1'b0;
         half      <= 1'b0;
         shift     <= '0;
         addr      <= '0;
         data_sh   <= '0;
         wr_hi     <= '0;
         sio_o     <= '0;
         sio_oe    <= 1'b0;
         busy      <= 1'b0;
         cmd_error <= 1'b0;
      end else begin
         cmd_error <= 1'b0;
         busy      <= ~cs_s;
         if (cs_s) begin
            state   <= IDLE;
            nib_cnt <= '0;
            half    <= 1'b0;
            sio_oe  <= 1'b0;
            sio_o   <= '0;
         end else begin
            case (state)
               IDLE: begin
                  state   <= CMD;
                  nib_cnt <= '0;
                  half    <= 1'b0;
               end
               CMD: if (rise) begin
                  shift <= shift_next;
                  if (nib_cnt == 3'd1) begin
                     nib_cnt <= '0;
                     case (shift_next[7:0])
                        8'h03: begin is_write <= 1'b0; state <= ADDR; end
                        8'h02: begin is_write <= 1'b1; state <= ADDR; end
                        default: begin state <= IGNORE; cmd_error <= 1'b1; end
                     endcase
                  end else begin
                     nib_cnt <= nib_cnt + 3'd1;
                  end
               end
               ADDR: if (rise) begin
                  shift <= shift_next;
                  if (nib_cnt == 3'd5) begin
                     nib_cnt <= '0;
                     half    <= 1'b0;
                     addr    <= shift_next[ADDR_WIDTH-1:0];
                     state   <= is_write ? WRITE : DUMMY;
                  end else begin
                     nib_cnt <= nib_cnt + 3'd1;
                  end
               end
               DUMMY: if (rise) begin
                  if (nib_cnt == 3'd1) begin
                     nib_cnt <= '0;
                     half    <= 1'b0;
                     data_sh <= mem[addr];
                     state   <= READ;
                  end else begin
                     nib_cnt <= nib_cnt + 3'd1;
                  end
               end
               READ: if (fall) begin
                  sio_oe <= 1'b1;
                  if (!half) begin
                     sio_o <= data_sh[7:4];
                     half  <= 1'b1;
                  end else begin
                     // low nibble out: advance and prefetch so the next fall has data ready
                     sio_o   <= data_sh[3:0];
                     half    <= 1'b0;
                     addr    <= addr_inc;
                     data_sh <= mem[addr_inc];
                  end
               end
               WRITE: if (rise) begin
                  if (!half) begin
                     wr_hi <= sio_s;
                     half  <= 1'b1;
                  end else begin
                     half <= 1'b0;
                     addr <= addr_inc;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // SIO write is issued last so it wins a same-cycle collision with the backdoor
   always_ff @(posedge clk) begin
      if (load_we)
         mem[load_addr] <= load_data;
      if (mem_we)
         mem[addr] <= {wr_hi, sio_s};
   end

endmodule

// File: tb/tb_qspi_sram_responder.sv
// Directed bench for qspi_sram_responder: acts as SQI master, checks read/write data and status outputs.
`timescale 1ns/1ps
module tb_qspi_sram_responder;

   localparam int AW = 10;
   localparam int H  = 8;  // sck half period in clk cycles

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          cs_n = 1'b1;
   logic          sck = 1'b0;
   logic [3:0]    sio_i = '0;
   logic [3:0]    sio_o;
   logic          sio_oe;
   logic          load_we = 1'b0;
   logic [AW-1:0] load_addr = '0;
   logic [7:0]    load_data = '0;
   logic          busy;
   logic          cmd_error;

   int checks = 0;
   int errors = 0;
   int err_pulses = 0;
   int oe_hits = 0;

   qspi_sram_responder #(.ADDR_WIDTH(AW), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset), .cs_n(cs_n), .sck(sck), .sio_i(sio_i),
      .sio_o(sio_o), .sio_oe(sio_oe), .load_we(load_we), .load_addr(load_addr),
      .load_data(load_data), .busy(busy), .cmd_error(cmd_error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (cmd_error) err_pulses <= err_pulses + 1;
      if (sio_oe) oe_hits <= oe_hits + 1;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic half_wait();
      repeat (H) @(negedge clk);
   endtask

   task automatic backdoor(input logic [AW-1:0] a, input logic [7:0] d);
      @(negedge clk);
      load_we = 1'b1; load_addr = a; load_data = d;
      @(negedge clk);
      load_we = 1'b0;
   endtask

   task automatic send_nib(input logic [3:0] n);
      sio_i = n;
      half_wait();
      sck = 1'b1;
      half_wait();
      sck = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_nib(b[7:4]);
      send_nib(b[3:0]);
   endtask

   task automatic start_xfer(input logic [7:0] cmd, input logic [23:0] a);
      cs_n = 1'b0;
      half_wait();
      send_byte(cmd);
      for (int i = 5; i >= 0; i--) send_nib(a[i*4 +: 4]);
   endtask

   task automatic end_xfer();
      half_wait();
      cs_n = 1'b1;
      repeat (H) @(negedge clk);
   endtask

   task automatic read_nib(output logic [3:0] n);
      half_wait();
      n = sio_o;
      sck = 1'b1;
      half_wait();
      sck = 1'b0;
   endtask

   task automatic read_byte(output logic [7:0] b);
      logic [3:0] hi, lo;
      read_nib(hi);
      read_nib(lo);
      b = {hi, lo};
   endtask

   task automatic write_bytes(input logic [23:0] a, input logic [7:0] d0, input int n,
                              input logic [7:0] d1, input logic [7:0] d2);
      start_xfer(8'h02, a);
      send_byte(d0);
      if (n > 1) send_byte(d1);
      if (n > 2) send_byte(d2);
      end_xfer();
   endtask

   task automatic read_check(input string tag, input logic [23:0] a, input int n,
                             input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
      logic [7:0] b;
      logic [7:0] exp [3];
      exp[0] = e0; exp[1] = e1; exp[2] = e2;
      start_xfer(8'h03, a);
      send_nib(4'h0);
      send_nib(4'h0);
      for (int i = 0; i < n; i++) begin
         read_byte(b);
         check($sformatf("%s_b%0d", tag, i), b, exp[i]);
      end
      end_xfer();
   endtask

   initial begin
      logic [3:0] nib;
      logic [3:0] seq [4];
      int pulses0, oe0;
      seq[0] = 4'hA; seq[1] = 4'h5; seq[2] = 4'h3; seq[3] = 4'hC;

      repeat (3) @(negedge clk);
      check("rst_sio_oe", 8'(sio_oe), 8'h0);
      check("rst_sio_o", 8'(sio_o), 8'h0);
      check("rst_busy", 8'(busy), 8'h0);
      check("rst_cmd_error", 8'(cmd_error), 8'h0);
      reset = 1'b0;
      repeat (4) @(negedge clk);

      // backdoor load then nibble-level read
      backdoor(10'h010, 8'hA5);
      backdoor(10'h011, 8'h3C);
      start_xfer(8'h03, 24'h000010);
      check("busy_active", 8'(busy), 8'h1);
      send_nib(4'h0);
      check("oe_before_data", 8'(sio_oe), 8'h0);
      sio_i = 4'h0;
      half_wait();
      sck = 1'b1;
      half_wait();
      check("oe_at_last_dummy", 8'(sio_oe), 8'h0);
      sck = 1'b0;
      for (int i = 0; i < 4; i++) begin
         read_nib(nib);
         check($sformatf("rd_nib%0d", i), 8'(nib), 8'(seq[i]));
         check($sformatf("rd_oe%0d", i), 8'(sio_oe), 8'h1);
      end
      end_xfer();
      check("oe_after_cs", 8'(sio_oe), 8'h0);
      check("busy_after_cs", 8'(busy), 8'h0);

      // write across the top of memory and read back with wrap
      write_bytes(24'h0003FE, 8'h11, 3, 8'h22, 8'h33);
      read_check("wrap", 24'h0003FE, 3, 8'h11, 8'h22, 8'h33);
      read_check("wrap0", 24'h000000, 1, 8'h33, 8'h00, 8'h00);

      // partial byte is dropped on cs_n rise
      backdoor(10'h021, 8'h5A);
      start_xfer(8'h02, 24'h000020);
      send_byte(8'h77);
      send_nib(4'h9);
      end_xfer();
      read_check("partial", 24'h000020, 2, 8'h77, 8'h5A, 8'h00);

      // unsupported command
      pulses0 = err_pulses;
      oe0 = oe_hits;
      start_xfer(8'h05, 24'h000020);
      send_byte(8'h00);
      send_byte(8'h00);
      end_xfer();
      check("cmd_error_pulses", 8'(err_pulses - pulses0), 8'h1);
      check("ignore_oe", 8'(oe_hits - oe0), 8'h0);
      read_check("after_ignore", 24'h000020, 2, 8'h77, 8'h5A, 8'h00);

      // upper address bits are dropped
      write_bytes(24'hFFF005, 8'hC3, 1, 8'h00, 8'h00);
      read_check("addr_trunc", 24'h000005, 1, 8'hC3, 8'h00, 8'h00);

      // reset in the data phase
      start_xfer(8'h03, 24'h000010);
      send_nib(4'h0);
      send_nib(4'h0);
      read_nib(nib);
      check("pre_rst_nib", 8'(nib), 8'hA);
      repeat (H / 2) @(negedge clk);
      check("pre_rst_oe", 8'(sio_oe), 8'h1);
      reset = 1'b1;
      #1;
      check("rst_mid_oe", 8'(sio_oe), 8'h0);
      check("rst_mid_sio_o", 8'(sio_o), 8'h0);
      cs_n = 1'b1;
      sck = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      read_check("post_rst", 24'h000010, 2, 8'hA5, 8'h3C, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
